router_sw_alloc: RTL and testbench

- Switch allocator and credit tracker for the mesh router datapath.
- Each cycle it decides which input port drives each output port of the crossbar, and grants one flit per input.
- Arbitration is round-robin per output and wormhole-locked: an output stays with its owner from head flit to tail flit.
- Grants are issued only when downstream credit exists; credits are returned through the per-port flow-control inputs.

---
 rtl/router_sw_alloc_if.sv | 34 +++
 rtl/router_sw_alloc.sv | 170 +++++++++++++++++
 tb/tb_router_sw_alloc.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_sw_alloc_if.sv
`default_nettype none
// ============================================================================
// Module      : router_sw_alloc_if
// Description : Request / grant / crossbar-select bundle between the router
//               input stage and the switch allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_sw_alloc_if #(
    parameter int NUM_PORTS      = 2,
    parameter int PORT_IDX_WIDTH = 1
);
    logic [NUM_PORTS-1:0]                req_valid;
    logic [NUM_PORTS*PORT_IDX_WIDTH-1:0] req_dest;
    logic [NUM_PORTS-1:0]                req_head;
    logic [NUM_PORTS-1:0]                req_tail;
    logic [NUM_PORTS-1:0]                credit_in;
    logic [NUM_PORTS-1:0]                gnt;
    logic [NUM_PORTS*PORT_IDX_WIDTH-1:0] xbar_sel;
    logic [NUM_PORTS-1:0]                xbar_valid;
    logic                                error;

    // Input stage / flow-control side
    modport master (
        output req_valid, req_dest, req_head, req_tail, credit_in,
        input  gnt, xbar_sel, xbar_valid, error
    );

    // Allocator side
    modport slave (
        input  req_valid, req_dest, req_head, req_tail, credit_in,
        output gnt, xbar_sel, xbar_valid, error
    );
endinterface
`default_nettype wire

// File: rtl/router_sw_alloc.sv
`default_nettype none
// ============================================================================
// Module      : router_sw_alloc
// Description : Per-output round-robin, wormhole-locked switch allocator with
//               downstream credit tracking and a sticky protocol error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module router_sw_alloc #(
    parameter int NUM_PORTS      = 2,
    parameter int PORT_IDX_WIDTH = 1,
    parameter int BUF_DEPTH      = 4,
    parameter int CRED_WIDTH     = 3
) (
    input wire logic         clk,
    input wire logic         reset,
    router_sw_alloc_if.slave bus
);

    localparam logic [0:0]            c_ST_IDLE   = 1'b0;
    localparam logic [0:0]            c_ST_LOCKED = 1'b1;
    localparam logic [CRED_WIDTH-1:0] c_CRED_MAX  = CRED_WIDTH'(BUF_DEPTH);
    localparam logic [CRED_WIDTH-1:0] c_CRED_ONE  = CRED_WIDTH'(1);

    logic [NUM_PORTS-1:0]                     r_state, w_state_nxt;
    logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0] r_owner, w_owner_nxt;
    logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0] r_rr_ptr, w_rr_nxt;
    logic [NUM_PORTS-1:0][CRED_WIDTH-1:0]     r_credit, w_credit_nxt;
    logic                                     r_error;

    logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0] w_dest;
    logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0] w_sel;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]      w_cand;
    logic [NUM_PORTS-1:0]                     w_owns;
    logic [NUM_PORTS-1:0]                     w_proto_err;
    logic [NUM_PORTS-1:0]                     w_ovf;
    logic [NUM_PORTS-1:0]                     w_xv;
    logic [NUM_PORTS-1:0]                     w_gnt;
    logic [PORT_IDX_WIDTH-1:0]                w_idx;
    logic                                     w_err_set;

    // Cyclic port index: (a + k) mod NUM_PORTS, valid for k < NUM_PORTS
    function automatic logic [PORT_IDX_WIDTH-1:0] f_wrap_add(
        input logic [PORT_IDX_WIDTH-1:0] a,
        input int                        k
    );
        int s;
        s = int'(a) + k;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return s[PORT_IDX_WIDTH-1:0];
    endfunction

    // The packed 2-D view lines slice i up with bits [i*W +: W]
    assign w_dest = bus.req_dest;

    // Which inputs currently hold a wormhole lock on some output
    always_comb begin
        w_owns = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (r_state[o] == c_ST_LOCKED) begin
                w_owns[r_owner[o]] = 1'b1;
            end
        end
    end

    // Protocol checks and idle-arbitration candidates per output
    always_comb begin
        w_cand      = '0;
        w_proto_err = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Body flit with no lock, or a new head while still owning a lock
            w_proto_err[i] = bus.req_valid[i] &
                             (bus.req_head[i] ? w_owns[i] : ~w_owns[i]);
            for (int o = 0; o < NUM_PORTS; o++) begin
                w_cand[o][i] = bus.req_valid[i] & bus.req_head[i] & ~w_owns[i] &
                               (w_dest[i] == PORT_IDX_WIDTH'(o));
            end
        end
    end

    // FSM output logic: per-output winner selection and input grants
    always_comb begin
        w_xv  = '0;
        w_sel = '0;
        w_gnt = '0;
        w_idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (r_credit[o] != '0) begin
                if (r_state[o] == c_ST_IDLE) begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        w_idx = f_wrap_add(r_rr_ptr[o], k);
                        if (!w_xv[o] && w_cand[o][w_idx]) begin
                            w_xv[o]  = 1'b1;
                            w_sel[o] = w_idx;
                        end
                    end
                end else if (bus.req_valid[r_owner[o]] && !bus.req_head[r_owner[o]] &&
                             (w_dest[r_owner[o]] == PORT_IDX_WIDTH'(o))) begin
                    w_xv[o]  = 1'b1;
                    w_sel[o] = r_owner[o];
                end
            end
            if (w_xv[o]) begin
                w_gnt[w_sel[o]] = 1'b1;
            end
        end
    end

    // FSM next-state logic: lock transitions, pointer advance, credit count
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr_ptr;
        w_credit_nxt = r_credit;
        w_ovf        = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_xv[o]) begin
                if (r_state[o] == c_ST_IDLE) begin
                    w_rr_nxt[o] = f_wrap_add(w_sel[o], 1);
                    if (!bus.req_tail[w_sel[o]]) begin
                        w_state_nxt[o] = c_ST_LOCKED;
                        w_owner_nxt[o] = w_sel[o];
                    end
                end else if (bus.req_tail[r_owner[o]]) begin
                    w_state_nxt[o] = c_ST_IDLE;
                end
            end
            case ({w_xv[o], bus.credit_in[o]})
                2'b10:   w_credit_nxt[o] = r_credit[o] - c_CRED_ONE;
                2'b01: begin
                    // A return into a full buffer is dropped and flagged
                    if (r_credit[o] == c_CRED_MAX) begin
                        w_ovf[o] = 1'b1;
                    end else begin
                        w_credit_nxt[o] = r_credit[o] + c_CRED_ONE;
                    end
                end
                default: w_credit_nxt[o] = r_credit[o];
            endcase
        end
    end

    assign w_err_set = (|w_proto_err) | (|w_ovf);

    // FSM state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= {NUM_PORTS{c_ST_IDLE}};
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_credit <= {NUM_PORTS{c_CRED_MAX}};
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_credit <= w_credit_nxt;
            r_error  <= r_error | w_err_set;
        end
    end

    // Grants and crossbar controls are suppressed while reset is held
    assign bus.gnt        = reset ? w_gnt : '0;
    assign bus.xbar_valid = reset ? w_xv  : '0;
    assign bus.xbar_sel   = reset ? w_sel : '0;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_router_sw_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_sw_alloc
// Description : Directed self-checking bench for the switch allocator
//               (NUM_PORTS=2, BUF_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_sw_alloc;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    router_sw_alloc_if #(.NUM_PORTS(2), .PORT_IDX_WIDTH(1)) bus ();

    router_sw_alloc #(
        .NUM_PORTS      (2),
        .PORT_IDX_WIDTH (1),
        .BUF_DEPTH      (4),
        .CRED_WIDTH     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bit i of every vector belongs to input (or output) i
    task automatic drive(input logic [1:0] v, input logic [1:0] d, input logic [1:0] h,
                         input logic [1:0] t, input logic [1:0] c);
        bus.req_valid = v;
        bus.req_dest  = d;
        bus.req_head  = h;
        bus.req_tail  = t;
        bus.credit_in = c;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [1:0] eg;
        reset = 1'b0;
        drive(2'b11, 2'b10, 2'b11, 2'b11, 2'b00);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_gnt: got %b expected 00", bus.gnt);
            end
            n_checks++;
            if (bus.xbar_valid !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_xv: got %b expected 00", bus.xbar_valid);
            end
            n_checks++;
            if (bus.error !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_error: got %b expected 0", bus.error);
            end
            next_cycle();
        end
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            eg = (c < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg || bus.xbar_valid !== eg) begin
                n_errors++;
                $display("FAIL reset_credit_drain c%0d: gnt %b xv %b expected %b",
                         c, bus.gnt, bus.xbar_valid, eg);
            end
            if (c < 4) begin
                n_checks++;
                if (bus.xbar_sel !== 2'b10) begin
                    n_errors++;
                    $display("FAIL reset_sel c%0d: got %b expected 10", c, bus.xbar_sel);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] eg [5];
        logic       es [5];
        eg = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        es = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        drive(2'b11, 2'b11, 2'b11, 2'b11, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c] || bus.xbar_valid !== {eg[c] != 2'b00, 1'b0}) begin
                n_errors++;
                $display("FAIL rr_gnt c%0d: gnt %b xv %b expected gnt %b",
                         c, bus.gnt, bus.xbar_valid, eg[c]);
            end
            if (c < 4) begin
                n_checks++;
                if (bus.xbar_sel[1] !== es[c]) begin
                    n_errors++;
                    $display("FAIL rr_sel c%0d: got %b expected %b", c, bus.xbar_sel[1], es[c]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_wormhole;
        logic [1:0] vv [5];
        logic [1:0] hv [5];
        logic [1:0] tv [5];
        logic [1:0] eg [5];
        vv = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01};
        hv = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        tv = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b01};
        eg = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(vv[c], 2'b00, hv[c], tv[c], 2'b00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin
                n_errors++;
                $display("FAIL wormhole_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]);
            end
            if (c < 4) begin
                n_checks++;
                if (bus.xbar_sel[0] !== eg[c][1] || bus.xbar_valid !== 2'b01) begin
                    n_errors++;
                    $display("FAIL wormhole_sel c%0d: sel %b xv %b expected sel %b xv 01",
                             c, bus.xbar_sel[0], bus.xbar_valid, eg[c][1]);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL wormhole_error: got %b expected 0", bus.error);
        end
        next_cycle();
    endtask

    task automatic test_credit_stall;
        logic [1:0] hv [8];
        logic [1:0] cv [8];
        logic [1:0] eg [8];
        hv = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        cv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        eg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(2'b01, 2'b00, hv[c], 2'b00, cv[c]);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin
                n_errors++;
                $display("FAIL credit_stall_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL credit_stall_error: got %b expected 0", bus.error);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [1:0] eg;
        apply_reset();
        drive(2'b01, 2'b00, 2'b01, 2'b01, 2'b01);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== 2'b01 || bus.error !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_gnt c%0d: gnt %b err %b expected gnt 01 err 0",
                         c, bus.gnt, bus.error);
            end
            next_cycle();
        end
        drive(2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        for (int c = 0; c < 5; c++) begin
            eg = (c < 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg || bus.error !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_drain c%0d: gnt %b err %b expected gnt %b err 0",
                         c, bus.gnt, bus.error, eg);
            end
            next_cycle();
        end
    endtask

    task automatic test_errors;
        logic [1:0] eg;
        // Credit return into a full output
        apply_reset();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
        @(negedge clk);
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_pre: got %b expected 0", bus.error);
        end
        next_cycle();
        drive(2'b10, 2'b10, 2'b10, 2'b10, 2'b00);
        for (int c = 0; c < 5; c++) begin
            eg = (c < 4) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg || bus.error !== 1'b1) begin
                n_errors++;
                $display("FAIL ovf_sat c%0d: gnt %b err %b expected gnt %b err 1",
                         c, bus.gnt, bus.error, eg);
            end
            next_cycle();
        end
        // Body flit on an input that owns nothing
        apply_reset();
        drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b00 || bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL body_idle: gnt %b err %b expected gnt 00 err 0", bus.gnt, bus.error);
        end
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.error !== 1'b1) begin
                n_errors++;
                $display("FAIL body_sticky c%0d: got %b expected 1", c, bus.error);
            end
            next_cycle();
        end
        // Second head flit from the owner of a locked output
        apply_reset();
        drive(2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL owner_head_lock: got %b expected 01", bus.gnt);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b00 || bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL owner_head_gnt: gnt %b err %b expected gnt 00 err 0", bus.gnt, bus.error);
        end
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        n_checks++;
        if (bus.error !== 1'b1) begin
            n_errors++;
            $display("FAIL owner_head_err: got %b expected 1", bus.error);
        end
        // Only reset clears the flag
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_errors++;
            $display("FAIL error_clear: got %b expected 0", bus.error);
        end
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_back_to_back();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
